// File: rtl/decoder_sel_sequencer_if.sv
// Control/select bundle between a sweep controller and decoder_sel_sequencer.
interface decoder_sel_sequencer_if;
    logic       start;
    logic       stop;
    logic       cont;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic       a;
    logic       b;
    logic       c;
    logic       valid;
    logic       busy;
    logic       step;
    logic       done;

    modport master (
        output start, stop, cont, dir, load, load_val,
        input  a, b, c, valid, busy, step, done
    );

    modport slave (
        input  start, stop, cont, dir, load, load_val,
        output a, b, c, valid, busy, step, done
    );
endinterface

// File: rtl/decoder_sel_sequencer.sv
// Steps a 3-to-8 decoder select through all eight codes, DWELL cycles each.
// Define SEL_SEQ_GRAY_EN to present the code Gray-encoded on {a,b,c}.
module decoder_sel_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    decoder_sel_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [2:0] sweep_q, sweep_d;
    logic [7:0] dwell_q, dwell_d;
    logic       cont_q, cont_d;
    logic       dir_q, dir_d;
    logic       step_q, step_d;

    logic       dwell_end;
    logic       sweep_last;
    logic [2:0] code_next;
    logic [2:0] sel;

    assign dwell_end  = (dwell_q == DWELL_LAST);
    assign sweep_last = (sweep_q == 3'd7);
    assign code_next  = dir_q ? (code_q - 3'd1) : (code_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            sweep_q <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            sweep_q <= sweep_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        sweep_d = sweep_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Load lands in the same edge as start, so the sweep begins at load_val.
                if (bus.load) code_d = bus.load_val;
                if (bus.start) begin
                    state_d = S_SWEEP;
                    cont_d  = bus.cont;
                    dir_d   = bus.dir;
                    dwell_d = '0;
                    sweep_d = '0;
                end
            end
            S_SWEEP: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (dwell_end) begin
                    dwell_d = '0;
                    code_d  = code_next;
                    sweep_d = sweep_q + 3'd1;
                    if (!cont_q && sweep_last) state_d = S_DONE;
                    else                       step_d  = 1'b1;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SEL_SEQ_GRAY_EN
    assign sel = code_q ^ (code_q >> 1);
`else
    assign sel = code_q;
`endif

    assign {bus.a, bus.b, bus.c} = sel;
    assign bus.valid = (state_q == S_SWEEP);
    assign bus.busy  = (state_q == S_SWEEP);
    assign bus.step  = step_q;
    assign bus.done  = (state_q == S_DONE);

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Directed bench for decoder_sel_sequencer: DWELL=4 and DWELL=1 instances.
module tb_decoder_sel_sequencer;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    decoder_sel_sequencer_if bus0();
    decoder_sel_sequencer_if bus1();

    decoder_sel_sequencer #(.DWELL(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    decoder_sel_sequencer #(.DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] sel_of(input logic [2:0] code);
`ifdef SEL_SEQ_GRAY_EN
        return code ^ (code >> 1);
`else
        return code;
`endif
    endfunction

    // Observed status packed as {valid, busy, step, done, a, b, c}.
    function automatic logic [6:0] obs0();
        return {bus0.valid, bus0.busy, bus0.step, bus0.done, bus0.a, bus0.b, bus0.c};
    endfunction

    function automatic logic [6:0] obs1();
        return {bus1.valid, bus1.busy, bus1.step, bus1.done, bus1.a, bus1.b, bus1.c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.start = 0; bus0.stop = 0; bus0.cont = 0; bus0.dir = 0; bus0.load = 0; bus0.load_val = '0;
        bus1.start = 0; bus1.stop = 0; bus1.cont = 0; bus1.dir = 0; bus1.load = 0; bus1.load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        if (obs0() !== 7'b0000_000) begin
            $display("FAIL reset_dut0: got %b expected %b", obs0(), 7'b0000_000);
            errors++;
        end
        checks++;
        if (obs1() !== 7'b0000_000) begin
            $display("FAIL reset_dut1: got %b expected %b", obs1(), 7'b0000_000);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Single sweep; optionally pulses start+load(3) mid-sweep at index inj.
    task automatic test_sweep(input string name, input logic [2:0] sc, input logic d, input int inj);
        logic [2:0] ec;
        logic [6:0] exp_v;
        bus0.load = 1; bus0.load_val = sc; bus0.start = 1; bus0.dir = d; bus0.cont = 0;
        tick();
        // Flip dir/cont after start to confirm they were latched.
        bus0.load = 0; bus0.start = 0; bus0.dir = ~d; bus0.cont = 1; bus0.load_val = '0;
        for (int k = 0; k < 32; k++) begin
            ec = d ? 3'(sc - 3'(k / 4)) : 3'(sc + 3'(k / 4));
            exp_v = {1'b1, 1'b1, (k % 4 == 0 && k != 0), 1'b0, sel_of(ec)};
            if (obs0() !== exp_v) begin
                $display("FAIL %s k=%0d: got %b expected %b", name, k, obs0(), exp_v);
                errors++;
            end
            checks++;
            if (k == inj) begin
                bus0.start = 1; bus0.load = 1; bus0.load_val = 3'd3;
            end else begin
                bus0.start = 0; bus0.load = 0; bus0.load_val = '0;
            end
            tick();
        end
        bus0.start = 0; bus0.load = 0; bus0.dir = 0; bus0.cont = 0;
        exp_v = {4'b0001, sel_of(sc)};
        if (obs0() !== exp_v) begin
            $display("FAIL %s_done: got %b expected %b", name, obs0(), exp_v);
            errors++;
        end
        checks++;
        tick();
        exp_v = {4'b0000, sel_of(sc)};
        if (obs0() !== exp_v) begin
            $display("FAIL %s_idle: got %b expected %b", name, obs0(), exp_v);
            errors++;
        end
        checks++;
    endtask

    task automatic test_load_idle();
        bus0.load = 1; bus0.load_val = 3'd5;
        tick();
        bus0.load = 0; bus0.load_val = '0;
        if (obs0() !== {4'b0000, sel_of(3'd5)}) begin
            $display("FAIL load_idle: got %b expected %b", obs0(), {4'b0000, sel_of(3'd5)});
            errors++;
        end
        checks++;
    endtask

    task automatic test_cont_stop();
        logic [6:0] exp_v;
        bus0.load = 1; bus0.load_val = 3'd6; bus0.start = 1; bus0.dir = 0; bus0.cont = 1;
        tick();
        bus0.load = 0; bus0.start = 0; bus0.cont = 0; bus0.load_val = '0;
        for (int k = 0; k < 40; k++) begin
            exp_v = {1'b1, 1'b1, (k % 4 == 0 && k != 0), 1'b0, sel_of(3'(3'd6 + 3'(k / 4)))};
            if (obs0() !== exp_v) begin
                $display("FAIL cont k=%0d: got %b expected %b", k, obs0(), exp_v);
                errors++;
            end
            checks++;
            if (k == 39) bus0.stop = 1;
            tick();
        end
        bus0.stop = 0;
        // Stop landed on a dwell end: code stays at 7, no step.
        exp_v = {4'b0000, sel_of(3'd7)};
        if (obs0() !== exp_v) begin
            $display("FAIL cont_stop: got %b expected %b", obs0(), exp_v);
            errors++;
        end
        checks++;
        tick();
        if (obs0() !== exp_v) begin
            $display("FAIL cont_stop_hold: got %b expected %b", obs0(), exp_v);
            errors++;
        end
        checks++;
    endtask

    task automatic test_stop_dwell_end();
        bus0.load = 1; bus0.load_val = 3'd0; bus0.start = 1; bus0.dir = 0; bus0.cont = 0;
        tick();
        bus0.load = 0; bus0.start = 0;
        tick(); tick(); tick();
        if (obs0() !== {4'b1100, sel_of(3'd0)}) begin
            $display("FAIL stop_pre: got %b expected %b", obs0(), {4'b1100, sel_of(3'd0)});
            errors++;
        end
        checks++;
        bus0.stop = 1;
        tick();
        bus0.stop = 0;
        if (obs0() !== {4'b0000, sel_of(3'd0)}) begin
            $display("FAIL stop_dwell_end: got %b expected %b", obs0(), {4'b0000, sel_of(3'd0)});
            errors++;
        end
        checks++;
        bus0.stop = 1;
        tick();
        bus0.stop = 0;
        if (obs0() !== {4'b0000, sel_of(3'd0)}) begin
            $display("FAIL stop_in_idle: got %b expected %b", obs0(), {4'b0000, sel_of(3'd0)});
            errors++;
        end
        checks++;
    endtask

    task automatic test_dwell1();
        logic [6:0] exp_v;
        bus1.load = 1; bus1.load_val = 3'd0; bus1.start = 1; bus1.dir = 0; bus1.cont = 0;
        tick();
        bus1.load = 0; bus1.start = 0;
        for (int k = 0; k < 8; k++) begin
            exp_v = {1'b1, 1'b1, (k != 0), 1'b0, sel_of(3'(k))};
            if (obs1() !== exp_v) begin
                $display("FAIL dwell1 k=%0d: got %b expected %b", k, obs1(), exp_v);
                errors++;
            end
            checks++;
            tick();
        end
        if (obs1() !== {4'b0001, sel_of(3'd0)}) begin
            $display("FAIL dwell1_done: got %b expected %b", obs1(), {4'b0001, sel_of(3'd0)});
            errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        bus0.load = 1; bus0.load_val = 3'd0; bus0.start = 1; bus0.dir = 0; bus0.cont = 0;
        tick();
        bus0.load = 0; bus0.start = 0;
        for (int k = 0; k < 10; k++) tick();
        if (obs0() !== {4'b1100, sel_of(3'd2)}) begin
            $display("FAIL pre_reset: got %b expected %b", obs0(), {4'b1100, sel_of(3'd2)});
            errors++;
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (obs0() !== 7'b0000_000) begin
            $display("FAIL reset_mid_sweep: got %b expected %b", obs0(), 7'b0000_000);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        if (obs0() !== 7'b0000_000) begin
            $display("FAIL post_reset_idle: got %b expected %b", obs0(), 7'b0000_000);
            errors++;
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sweep("single_up", 3'd0, 1'b0, -1);
        test_load_idle();
        test_sweep("single_down", 3'd5, 1'b1, -1);
        test_cont_stop();
        test_sweep("ignored_inputs", 3'd0, 1'b0, 5);
        test_stop_dwell_end();
        test_dwell1();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
